id_ex_skid_buffer: RTL and testbench

Parametrised, elastic successor to the fixed ID/EX pipeline register. It is a two-entry valid/ready skid buffer carrying an opaque payload, a control vector and a debug instruction word. It provides separate flush (kill) and bubble (block upstream) controls and saturating stall/idle performance counters. It sits between decode and execute, and the same block can be instanced at other stage boundaries.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/sat_counter.sv | 23 ++
 rtl/id_ex_skid_buffer.sv | 166 ++++++++++++++++
 tb/tb_id_ex_skid_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encodings, ID/EX control field layout and
// the state encoding used by the elastic stage buffers.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h00000013;
    localparam logic [3:0]  ALUCTRL_NOP = 4'hF;

    localparam int IDEX_CTRL_W      = 10;
    localparam int CTRL_MEM_READ    = 9;
    localparam int CTRL_MEM_WRITE   = 8;
    localparam int CTRL_REG_WRITE   = 7;
    localparam int CTRL_MEM_TO_REG  = 6;
    localparam int CTRL_ALU_SRC     = 5;
    localparam int CTRL_BRANCH      = 4;
    localparam int CTRL_ALU_LSB     = 0;

    function automatic logic [IDEX_CTRL_W-1:0] pack_idex_ctrl(
        input logic       mem_read,
        input logic       mem_write,
        input logic       reg_write,
        input logic       mem_to_reg,
        input logic       alu_src,
        input logic       branch,
        input logic [3:0] alu_ctrl
    );
        logic [IDEX_CTRL_W-1:0] v;
        v = '0;
        v[CTRL_MEM_READ]                  = mem_read;
        v[CTRL_MEM_WRITE]                 = mem_write;
        v[CTRL_REG_WRITE]                 = reg_write;
        v[CTRL_MEM_TO_REG]                = mem_to_reg;
        v[CTRL_ALU_SRC]                   = alu_src;
        v[CTRL_BRANCH]                    = branch;
        v[CTRL_ALU_LSB+3:CTRL_ALU_LSB]    = alu_ctrl;
        return v;
    endfunction

    // A NOP has no side effects: every enable low, ALU in its idle code.
    localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_NOP =
        pack_idex_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUCTRL_NOP);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    typedef enum logic [1:0] {
        MAIN_HOLD = 2'd0,
        MAIN_UP   = 2'd1,
        MAIN_SKID = 2'd2,
        MAIN_NOP  = 2'd3
    } main_sel_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised up counter with enable that sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/id_ex_skid_buffer.sv
// Two-entry valid/ready skid buffer between decode and execute, with flush,
// bubble and saturating stall/idle counters.
module id_ex_skid_buffer
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 128,
    parameter int                 CTRL_W    = 10,
    parameter logic [CTRL_W-1:0]  NOP_CTRL  = CTRL_W'(pipe_pkg::IDEX_CTRL_NOP),
    parameter logic [31:0]        NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter int                 CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [31:0]       up_instr,
    input  logic              bubble,
    input  logic              flush,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [31:0]       dn_instr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  idle_cnt
);

    skid_state_t       r_state;
    skid_state_t       w_state_next;
    main_sel_t         w_main_sel;
    logic              w_skid_load;
    logic              w_up_fire;
    logic              w_dn_fire;

    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [31:0]       r_main_instr;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [31:0]       r_skid_instr;

    // The skid entry being full is exactly state TWO.
    assign up_ready  = (r_state != ST_TWO) & ~bubble;
    assign dn_valid  = (r_state != ST_EMPTY);
    assign occupancy = r_state;
    assign w_up_fire = up_valid & up_ready;
    assign w_dn_fire = dn_valid & dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_up_fire) w_state_next = ST_ONE;
                ST_ONE: begin
                    if (w_up_fire && !w_dn_fire) begin
                        w_state_next = ST_TWO;
                    end else if (!w_up_fire && w_dn_fire) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO:   if (w_dn_fire) w_state_next = ST_ONE;
                default:  w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Main is reloaded with NOP values whenever it empties, so dn_* can be
    // driven straight from the registers without an output mux.
    always_comb begin
        w_main_sel  = MAIN_HOLD;
        w_skid_load = 1'b0;
        if (flush) begin
            w_main_sel = MAIN_NOP;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_up_fire) w_main_sel = MAIN_UP;
                ST_ONE: begin
                    if (w_up_fire && w_dn_fire) begin
                        w_main_sel = MAIN_UP;
                    end else if (w_up_fire) begin
                        w_skid_load = 1'b1;
                    end else if (w_dn_fire) begin
                        w_main_sel = MAIN_NOP;
                    end
                end
                ST_TWO:   if (w_dn_fire) w_main_sel = MAIN_SKID;
                default:  w_main_sel = MAIN_NOP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data  <= '0;
            r_main_ctrl  <= NOP_CTRL;
            r_main_instr <= NOP_INSTR;
        end else begin
            case (w_main_sel)
                MAIN_UP: begin
                    r_main_data  <= up_data;
                    r_main_ctrl  <= up_ctrl;
                    r_main_instr <= up_instr;
                end
                MAIN_SKID: begin
                    r_main_data  <= r_skid_data;
                    r_main_ctrl  <= r_skid_ctrl;
                    r_main_instr <= r_skid_instr;
                end
                MAIN_NOP: begin
                    r_main_data  <= '0;
                    r_main_ctrl  <= NOP_CTRL;
                    r_main_instr <= NOP_INSTR;
                end
                default: begin
                    r_main_data  <= r_main_data;
                    r_main_ctrl  <= r_main_ctrl;
                    r_main_instr <= r_main_instr;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_data  <= '0;
            r_skid_ctrl  <= NOP_CTRL;
            r_skid_instr <= NOP_INSTR;
        end else if (w_skid_load) begin
            r_skid_data  <= up_data;
            r_skid_ctrl  <= up_ctrl;
            r_skid_instr <= up_instr;
        end
    end

    assign dn_data  = r_main_data;
    assign dn_ctrl  = r_main_ctrl;
    assign dn_instr = r_main_instr;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (up_valid & ~up_ready),
        .o_count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_idle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (~dn_valid),
        .o_count (idle_cnt)
    );

endmodule

// File: tb/tb_id_ex_skid_buffer.sv
// Scoreboard bench for id_ex_skid_buffer: stimulus pushes accepted beats,
// a negedge monitor pops and compares every downstream handshake.
module tb_id_ex_skid_buffer;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, up_valid, up_ready, bubble, flush, dn_valid, dn_ready;
    logic [127:0] up_data, dn_data;
    logic [9:0]   up_ctrl, dn_ctrl;
    logic [31:0]  up_instr, dn_instr, stall_cnt, idle_cnt;
    logic [1:0]   occupancy;

    logic         rst4, up_valid4, up_ready4, bubble4, flush4, dn_valid4, dn_ready4;
    logic [127:0] up_data4, dn_data4;
    logic [9:0]   up_ctrl4, dn_ctrl4;
    logic [31:0]  up_instr4, dn_instr4;
    logic [1:0]   occupancy4;
    logic [3:0]   stall_cnt4, idle_cnt4;

    id_ex_skid_buffer u_dut (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
        .up_data(up_data), .up_ctrl(up_ctrl), .up_instr(up_instr),
        .bubble(bubble), .flush(flush), .dn_valid(dn_valid), .dn_ready(dn_ready),
        .dn_data(dn_data), .dn_ctrl(dn_ctrl), .dn_instr(dn_instr),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .idle_cnt(idle_cnt)
    );

    id_ex_skid_buffer #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst4), .up_valid(up_valid4), .up_ready(up_ready4),
        .up_data(up_data4), .up_ctrl(up_ctrl4), .up_instr(up_instr4),
        .bubble(bubble4), .flush(flush4), .dn_valid(dn_valid4), .dn_ready(dn_ready4),
        .dn_data(dn_data4), .dn_ctrl(dn_ctrl4), .dn_instr(dn_instr4),
        .occupancy(occupancy4), .stall_cnt(stall_cnt4), .idle_cnt(idle_cnt4)
    );

    typedef struct packed {
        logic [31:0]  instr;
        logic [127:0] data;
        logic [9:0]   ctrl;
    } beat_t;

    beat_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    logic         s_fire, s_dn_valid, s_up_ready;
    logic [31:0]  s_dn_instr;
    logic [9:0]   s_dn_ctrl;
    logic [127:0] s_dn_data;
    logic [1:0]   s_occ;

    function automatic logic [127:0] data_of(input logic [31:0] x);
        return {x, ~x, x + 32'd1, x ^ 32'hA5A5_0000};
    endfunction

    function automatic logic [9:0] ctrl_of(input logic [31:0] x);
        return x[9:0] ^ 10'h155;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs driven just after posedge, sampled at negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic bub,
                        input logic fl, input logic dr);
        beat_t b;
        up_valid = v;  up_instr = ins;  up_data = data_of(ins);  up_ctrl = ctrl_of(ins);
        bubble = bub;  flush = fl;  dn_ready = dr;
        @(negedge clk);
        s_fire     = up_valid & up_ready;
        s_up_ready = up_ready;
        s_dn_valid = dn_valid;
        s_dn_instr = dn_instr;
        s_dn_ctrl  = dn_ctrl;
        s_dn_data  = dn_data;
        s_occ      = occupancy;
        if (fl) begin
            sb_q.delete();
        end else if (s_fire) begin
            b.instr = ins;  b.data = data_of(ins);  b.ctrl = ctrl_of(ins);
            sb_q.push_back(b);
        end
        $display("t=%0t up_valid=%0b instr=%0h bubble=%0b flush=%0b dn_ready=%0b fire=%0b dn_valid=%0b dn_instr=%0h occ=%0d",
                 $time, v, ins, bub, fl, dr, s_fire, s_dn_valid, s_dn_instr, s_occ);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (dn_valid && dn_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", dn_instr);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_instr", dn_instr, e.instr);
                    chk("beat_data", dn_data, e.data);
                    chk("beat_ctrl", dn_ctrl, e.ctrl);
                end
            end else if (!dn_valid) begin
                chk("idle_nop_instr", dn_instr, 32'h00000013);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;  up_valid = 1'b0;  up_data = '0;  up_ctrl = '0;  up_instr = '0;
        bubble = 1'b0;  flush = 1'b0;  dn_ready = 1'b0;
        rst4 = 1'b1;  up_valid4 = 1'b0;  up_data4 = '0;  up_ctrl4 = '0;  up_instr4 = '0;
        bubble4 = 1'b0;  flush4 = 1'b0;  dn_ready4 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_dn_valid", dn_valid, 0);
        chk("rst_dn_instr", dn_instr, 32'h00000013);
        chk("rst_dn_ctrl", dn_ctrl, 10'h00F);
        chk("rst_dn_data", dn_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_up_ready", up_ready, 1);
        bubble = 1'b1;
        #1;
        chk("rst_up_ready_bubble", up_ready, 0);
        bubble = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_cnt_ramp", idle_cnt, k);
            chk("idle_cnt4_ramp", idle_cnt4, k);
            @(posedge clk);
            #1;
        end

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, i, 1'b0, 1'b0, 1'b1);
            chk("stream_fire", s_fire, 1);
            if (i > 1) begin
                chk("stream_latency_valid", s_dn_valid, 1);
                chk("stream_latency_instr", s_dn_instr, i - 1);
            end
        end
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("stream_last_instr", s_dn_instr, 8);
        chk("stream_stall_cnt", stall_cnt, 0);

        // Backpressure: two accepts then up_ready drops
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        chk("bp_fire_a", s_fire, 1);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        chk("bp_fire_b", s_fire, 1);
        chk("bp_ready_b", s_up_ready, 1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
            chk("bp_fire_c_blocked", s_fire, 0);
            chk("bp_occ_two", s_occ, 2);
        end
        chk("bp_stall_cnt", stall_cnt, 3);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
        chk("bp_rel_fire0", s_fire, 0);
        chk("bp_rel_a", s_dn_instr, 32'hA);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
        chk("bp_rel_fire1", s_fire, 1);
        chk("bp_rel_b", s_dn_instr, 32'hB);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("bp_rel_c_valid", s_dn_valid, 1);
        chk("bp_rel_c", s_dn_instr, 32'hC);
        chk("bp_stall_after", stall_cnt, 4);

        // Bubble: held beat drains, upstream blocked
        step(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
        chk("bub_fire_20", s_fire, 1);
        step(1'b1, 32'h21, 1'b1, 1'b0, 1'b1);
        chk("bub_ready0", s_up_ready, 0);
        chk("bub_drain_20", s_dn_instr, 32'h20);
        step(1'b1, 32'h21, 1'b1, 1'b0, 1'b1);
        chk("bub_ready1", s_up_ready, 0);
        chk("bub_empty_valid", s_dn_valid, 0);
        chk("bub_empty_instr", s_dn_instr, 32'h00000013);
        chk("bub_empty_ctrl", s_dn_ctrl, 10'h00F);
        chk("bub_empty_data", s_dn_data, 0);
        chk("bub_stall_cnt", stall_cnt, 6);

        // Flush in TWO while 0xD is offered
        step(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b0, 1'b1, 1'b0);
        chk("fl2_occ_before", s_occ, 2);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("fl2_occ", s_occ, 0);
        chk("fl2_valid", s_dn_valid, 0);
        chk("fl2_instr", s_dn_instr, 32'h00000013);
        chk("fl2_stall_kept", stall_cnt, 7);

        // Flush in ONE with a real up_fire of 0xE, then prove 0xE is gone
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hE, 1'b0, 1'b1, 1'b0);
        chk("fl1_fire_e", s_fire, 1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("fl1_occ", s_occ, 0);
        chk("fl1_valid", s_dn_valid, 0);
        step(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("fl1_next_instr", s_dn_instr, 32'h50);
        chk("fl1_stall_kept", stall_cnt, 7);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Narrow counter saturation and asynchronous reset
        chk("sat_idle4", idle_cnt4, 4'hF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat_idle4_hold", idle_cnt4, 4'hF);
        chk("dut4_valid", dn_valid4, 0);
        chk("dut4_occ", occupancy4, 0);
        chk("dut4_ready", up_ready4, 1);
        chk("dut4_stall", stall_cnt4, 0);
        chk("dut4_nop", {dn_instr4, dn_ctrl4}, {32'h00000013, 10'h00F});
        chk("dut4_data", dn_data4, 0);
        #2;
        rst4 = 1'b1;
        #1;
        chk("async_rst_idle4", idle_cnt4, 0);
        #1;
        rst4 = 1'b0;

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
